pipe_stage_regs: RTL
====================

// Module: pipe_stage_regs
// PURPOSE
//  Fetch/decode/execute pipeline register bank: PC, IF/ID and ID/EX registers, which act on the hazard unit's StallF/StallD/FlushE and on branch redirect.
//  Feeds RsD/RtD/RsE/RtE back to the hazard unit and counts stall/bubble cycles for performance checks.
// PARAMETERS
//  DATA_W    32           datapath / PC width
//  RESET_PC  32'h0000_0000 PCF value after reset
//  CNT_W     32           width of the saturating stall and bubble counters
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rst         in   1       synchronous, active-high reset
//  StallF      in   1       hold PC
//  StallD      in   1       hold IF/ID
//  FlushE      in   1       insert bubble into ID/EX
//  PCSrcD      in   1       branch taken in decode: redirect PC, squash IF/ID
//  PCBranchD   in   DATA_W  branch target
//  InstrF      in   32      instruction fetched at PCF
//  CtrlD       in   8       ctrl_t {RegWrite,MemtoReg,MemWrite,ALUControl[2:0],ALUSrc,RegDst}
//  RD1D        in   DATA_W  register file read port 1
//  RD2D        in   DATA_W  register file read port 2
//  PCF         out  DATA_W  current fetch PC
//  InstrD      out  32      decode-stage instruction
//  PCPlus4D    out  DATA_W  PC+4 of InstrD
//  RsD         out  5       InstrD[25:21]
//  RtD         out  5       InstrD[20:16]
//  ValidD      out  1       IF/ID holds a real instruction
//  CtrlE       out  8       execute-stage control, ctrl_t
//  RD1E        out  DATA_W  execute operand A
//  RD2E        out  DATA_W  execute operand B
//  RsE         out  5       execute Rs
//  RtE         out  5       execute Rt
//  RdE         out  5       execute Rd
//  SignImmE    out  DATA_W  sign-extended InstrD[15:0], registered
//  ValidE      out  1       ID/EX holds a real instruction
//  StallCnt    out  CNT_W   cycles with StallF=1
//  BubbleCnt   out  CNT_W   cycles with FlushE=1
// BEHAVIOUR
//  Reset: PCF=RESET_PC. All other outputs 0, including the counters. Reset overrides every other input.
//  PC: if StallF, hold. Else PCF <= PCSrcD ? PCBranchD : PCF+4, wrapping modulo 2^DATA_W.
//  IF/ID: if StallD, hold, and PCSrcD is ignored that cycle.
//    Else if PCSrcD, clear: InstrD=0 (NOP), PCPlus4D=0, ValidD=0.
//    Else load InstrF and PCF+4, and set ValidD=1.
//  ID/EX: if FlushE, load a bubble: CtrlE=0, all data fields 0, ValidE=0.
//    Else load the decode values: CtrlD, RD1D, RD2D, InstrD fields, and ValidE=ValidD.
//    FlushE ignores StallD. StallD=1 with FlushE=1 is the load-use case: IF/ID holds and ID/EX bubbles in the same cycle.
//  StallF=1 with StallD=0 is legal but not produced by the hazard unit. The PC holds and IF/ID reloads the same InstrF.
//  Latency: 1 cycle per stage. InstrF sampled at edge n appears on InstrD after edge n; its operands reach *E after edge n+1.
//  Counters: +1 per cycle while the enabling input is high. They saturate at all-ones and never wrap.
//  RsD and RtD are combinational slices of InstrD, so the hazard unit sees them in the same cycle.
// STRUCTURE
//  mips_pipe_pkg holds: ctrl_t packed struct (8 bits), CTRL_BUBBLE='0, NOP_INSTR=32'h0, field-slice localparams.
//  Sub-module pipe_flop_enclr #(W) provides a register with en and synchronous clr (clr wins over en). It is instantiated for PC, IF/ID and ID/EX.
// TESTING
//  1. Reset with RESET_PC=32'h100, then 3 free cycles: PCF goes 100,104,108,10C; ValidD=1 from cycle 1; ValidE=1 from cycle 2.
//  2. Load-use: StallF=StallD=FlushE=1 for 1 cycle. PCF and InstrD hold. Next cycle CtrlE=0, ValidE=0. StallCnt=1, BubbleCnt=1.
//  3. PCSrcD=1 with PCBranchD=32'h200: next PCF=200, InstrD=0, ValidD=0. Following cycle ValidE=0.
//  4. PCSrcD=1 together with StallF=StallD=1: PCF, InstrD and ValidD are unchanged; the redirect is taken once the stall drops.
//  5. Preload StallCnt to all-ones-1 via a long stall: after 2 more stall cycles it reads all-ones and stays there.
//  6. Assert rst mid-stall with FlushE=1: next cycle PCF=RESET_PC, every other output 0, counters 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and instruction-field constants for the fetch/decode/execute
// pipeline register bank.
package mips_pipe_pkg;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic [2:0] alu_control;
      logic       alu_src;
      logic       reg_dst;
   } ctrl_t;

   localparam int CTRL_W     = 8;
   localparam int INSTR_W    = 32;
   localparam int REG_ADDR_W = 5;
   localparam int IMM_W      = 16;

   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int IMM_LSB = 0;

   localparam ctrl_t             CTRL_BUBBLE = ctrl_t'(8'h00);
   localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/pipe_flop_enclr.sv
// Register with load enable and synchronous clear; clear has priority over
// enable, and reset has priority over both.
module pipe_flop_enclr #(
   parameter int           W         = 32,
   parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // State register: reset, then clear, then load, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (clr) begin
         q <= {W{1'b0}};
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers steered by the hazard unit's stall,
// flush and branch-redirect controls, plus saturating stall/bubble counters.
module pipe_stage_regs
   import mips_pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  StallF,
   input  logic                  StallD,
   input  logic                  FlushE,
   input  logic                  PCSrcD,
   input  logic [DATA_W-1:0]     PCBranchD,
   input  logic [INSTR_W-1:0]    InstrF,
   input  ctrl_t                 CtrlD,
   input  logic [DATA_W-1:0]     RD1D,
   input  logic [DATA_W-1:0]     RD2D,
   output logic [DATA_W-1:0]     PCF,
   output logic [INSTR_W-1:0]    InstrD,
   output logic [DATA_W-1:0]     PCPlus4D,
   output logic [REG_ADDR_W-1:0] RsD,
   output logic [REG_ADDR_W-1:0] RtD,
   output logic                  ValidD,
   output ctrl_t                 CtrlE,
   output logic [DATA_W-1:0]     RD1E,
   output logic [DATA_W-1:0]     RD2E,
   output logic [REG_ADDR_W-1:0] RsE,
   output logic [REG_ADDR_W-1:0] RtE,
   output logic [REG_ADDR_W-1:0] RdE,
   output logic [DATA_W-1:0]     SignImmE,
   output logic                  ValidE,
   output logic [CNT_W-1:0]      StallCnt,
   output logic [CNT_W-1:0]      BubbleCnt
);

   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);
   localparam int IFID_W = INSTR_W + DATA_W + 1;
   localparam int IDEX_W = CTRL_W + 3 * DATA_W + 3 * REG_ADDR_W + 1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   logic [DATA_W-1:0] pc_plus4;
   logic [DATA_W-1:0] pc_next;
   logic              pc_en;
   logic              ifid_en;
   logic              ifid_clr;
   logic [IFID_W-1:0] ifid_d;
   logic [IFID_W-1:0] ifid_q;
   logic [DATA_W-1:0] sign_imm;
   logic [IDEX_W-1:0] idex_d;
   logic [IDEX_W-1:0] idex_q;

   // Next-PC selection and the load/clear controls for each stage.
   always_comb begin
      pc_plus4 = PCF + PC_STEP;
      pc_next  = pc_plus4;
      pc_en    = ~StallF;
      ifid_en  = ~StallD;
      // A stalled decode stage must keep its instruction even under a redirect.
      ifid_clr = PCSrcD & ~StallD;
      if (PCSrcD) begin
         pc_next = PCBranchD;
      end else begin
         pc_next = pc_plus4;
      end
      ifid_d   = {InstrF, pc_plus4, 1'b1};
      sign_imm = {{(DATA_W - IMM_W){InstrD[IMM_LSB + IMM_W - 1]}},
                  InstrD[IMM_LSB +: IMM_W]};
      idex_d   = {CtrlD, RD1D, RD2D,
                  InstrD[RS_LSB +: REG_ADDR_W],
                  InstrD[RT_LSB +: REG_ADDR_W],
                  InstrD[RD_LSB +: REG_ADDR_W],
                  sign_imm, ValidD};
   end

   pipe_flop_enclr #(.W(DATA_W), .RESET_VAL(RESET_PC)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .clr (1'b0),
      .d   (pc_next),
      .q   (PCF)
   );

   pipe_flop_enclr #(.W(IFID_W), .RESET_VAL({IFID_W{1'b0}})) u_ifid (
      .clk (clk),
      .rst (rst),
      .en  (ifid_en),
      .clr (ifid_clr),
      .d   (ifid_d),
      .q   (ifid_q)
   );

   // FlushE acts regardless of StallD, giving the load-use hold-plus-bubble.
   pipe_flop_enclr #(.W(IDEX_W), .RESET_VAL({IDEX_W{1'b0}})) u_idex (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .clr (FlushE),
      .d   (idex_d),
      .q   (idex_q)
   );

   assign {InstrD, PCPlus4D, ValidD} = ifid_q;
   assign {CtrlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, ValidE} = idex_q;

   assign RsD = InstrD[RS_LSB +: REG_ADDR_W];
   assign RtD = InstrD[RT_LSB +: REG_ADDR_W];

   // Saturating performance counters for stall and bubble cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         StallCnt  <= {CNT_W{1'b0}};
         BubbleCnt <= {CNT_W{1'b0}};
      end else begin
         if (StallF) begin
            StallCnt <= sat_inc(StallCnt);
         end else begin
            StallCnt <= StallCnt;
         end
         if (FlushE) begin
            BubbleCnt <= sat_inc(BubbleCnt);
         end else begin
            BubbleCnt <= BubbleCnt;
         end
      end
   end

endmodule
